pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 98 +++++++++
 tb/tb_pipelined_adder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Chunked ripple adder pipelined over STAGES register levels with valid/ready flow control.
// Optional build macro PIPELINED_ADDER_SATURATE_EN clamps the sum to all ones on a final carry.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    // WIDTH must be a multiple of STAGES; each stage resolves one CW-bit chunk.
    localparam int CW = WIDTH / STAGES;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The whole pipe moves as one unit, so it advances unless the output is held.
    logic w_advance;
    logic w_accept;

    assign w_advance = ~(out_valid & ~out_ready);
    assign in_ready  = w_advance;
    assign w_accept  = in_valid & in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_s_in;
        logic [WIDTH-1:0] w_s_next;
        logic             w_c_in;
        logic             w_v_in;
        logic [CW:0]      w_chunk;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_sum;
        logic             r_c;
        logic             r_v;
        logic             w_unused_ops;

        if (k == 0) begin : g_head
            assign w_a_in = a;
            assign w_b_in = b;
            assign w_s_in = '0;
            assign w_c_in = carry_in;
            assign w_v_in = w_accept;
        end else begin : g_body
            assign w_a_in = g_stage[k-1].r_a;
            assign w_b_in = g_stage[k-1].r_b;
            assign w_s_in = g_stage[k-1].r_sum;
            assign w_c_in = g_stage[k-1].r_c;
            assign w_v_in = g_stage[k-1].r_v;
        end

        assign w_chunk = {1'b0, w_a_in[k*CW +: CW]}
                       + {1'b0, w_b_in[k*CW +: CW]}
                       + {{CW{1'b0}}, w_c_in};

        always_comb begin
            w_s_next = w_s_in;
            w_s_next[k*CW +: CW] = w_chunk[CW-1:0];
        end

        // Already-added low operand chunks ride along but are never read again.
        assign w_unused_ops = ^{r_a, r_b};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_a   <= '0;
                r_b   <= '0;
                r_sum <= '0;
                r_c   <= 1'b0;
                r_v   <= 1'b0;
            end else if (w_advance) begin
                r_a   <= w_a_in;
                r_b   <= w_b_in;
                r_sum <= w_s_next;
                r_c   <= w_chunk[CW];
                r_v   <= w_v_in;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign carry_out = g_stage[STAGES-1].r_c;

`ifdef PIPELINED_ADDER_SATURATE_EN
    assign sum = g_stage[STAGES-1].r_c ? {WIDTH{1'b1}} : g_stage[STAGES-1].r_sum;
`else
    assign sum = g_stage[STAGES-1].r_sum;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: an 8-bit/2-stage instance for directed cases and a
// 32-bit/4-stage instance for random traffic, both checked against a+b+cin arithmetic.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready, s8_cin, s8_cout;
    logic [7:0] s8_a, s8_b, s8_sum;

    logic        s32_in_valid, s32_in_ready, s32_out_valid, s32_out_ready, s32_cin, s32_cout;
    logic [31:0] s32_a, s32_b, s32_sum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp8_q[$];
    logic [32:0] exp32_q[$];

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .a(s8_a), .b(s8_b), .carry_in(s8_cin),
        .out_valid(s8_out_valid), .out_ready(s8_out_ready),
        .sum(s8_sum), .carry_out(s8_cout)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s32_in_valid), .in_ready(s32_in_ready),
        .a(s32_a), .b(s32_b), .carry_in(s32_cin),
        .out_valid(s32_out_valid), .out_ready(s32_out_ready),
        .sum(s32_sum), .carry_out(s32_cout)
    );

    // Reference: {carry, sum} of a w-bit add, carry at bit 32 of the result.
    function automatic logic [32:0] ref_add(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic cin);
        logic [32:0] t;
        logic [31:0] mask;
        logic        c;
        t    = {1'b0, x} + {1'b0, y} + {32'd0, cin};
        c    = t[w];
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        t[31:0] = t[31:0] & mask;
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (c) t[31:0] = mask;
`endif
        return {c, t[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s8_in_valid = 1'b1; s8_a = 8'd1; s8_b = 8'd1; s8_cin = 1'b0; s8_out_ready = 1'b1;
        s32_in_valid = 1'b1; s32_a = 32'd5; s32_b = 32'd6; s32_cin = 1'b1; s32_out_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (s8_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b want 0", s8_out_valid); end
        n_checks++; if (s8_sum !== 8'd0) begin n_fail++; $display("FAIL reset_sum8: got %0d want 0", s8_sum); end
        n_checks++; if (s8_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout8: got %b want 0", s8_cout); end
        n_checks++; if (s8_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8: got %b want 1", s8_in_ready); end
        n_checks++; if (s32_out_valid !== 1'b0 || s32_sum !== 32'd0) begin n_fail++; $display("FAIL reset_out32: got v=%b sum=%0d want v=0 sum=0", s32_out_valid, s32_sum); end
        n_checks++; if (s32_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready32: got %b want 1", s32_in_ready); end
        rst_n = 1'b1;
        s8_in_valid = 1'b0;
        s32_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (s8_out_valid !== 1'b0 || s32_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_accept: got v8=%b v32=%b want 0 0", s8_out_valid, s32_out_valid);
            end
        end
    endtask

    // One transfer through the 2-stage instance: result visible after exactly two edges.
    task automatic add8(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic cin, input logic [7:0] want_sum, input logic want_c);
        s8_a = x; s8_b = y; s8_cin = cin; s8_in_valid = 1'b1; s8_out_ready = 1'b1;
        tick();
        s8_in_valid = 1'b0;
        n_checks++; if (s8_out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early: out_valid got %b want 0", name, s8_out_valid); end
        tick();
        n_checks++; if (s8_out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", name, s8_out_valid); end
        n_checks++; if (s8_sum !== want_sum || s8_cout !== want_c) begin
            n_fail++; $display("FAIL %s_result: got sum=%0d c=%b want sum=%0d c=%b", name, s8_sum, s8_cout, want_sum, want_c);
        end
    endtask

    task automatic test_directed;
        add8("basic", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0);
`ifdef PIPELINED_ADDER_SATURATE_EN
        add8("overflow", 8'd200, 8'd100, 1'b0, 8'd255, 1'b1);
        add8("carry_all", 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b1);
`else
        add8("overflow", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
        add8("carry_all", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
`endif
        add8("chunk_carry", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        tick();
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        int stall_left = 4;
        bit started = 0;
        bit stalled;
        logic [7:0] held = '0;
        exp8_q.delete();
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            s8_in_valid = (sent < 5);
            s8_a = 8'(sent + 1); s8_b = 8'(sent + 1); s8_cin = 1'b0;
            if (s8_out_valid && !started) started = 1;
            stalled = started && (stall_left > 0);
            s8_out_ready = !stalled;
            #1;
            if (stalled) begin
                n_checks++; if (s8_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", s8_in_ready); end
                n_checks++; if (s8_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b want 1", s8_out_valid); end
                if (stall_left == 4) held = s8_sum;
                else begin
                    n_checks++; if (s8_sum !== held) begin n_fail++; $display("FAIL bp_sum_stable: got %0d want %0d", s8_sum, held); end
                end
                stall_left--;
            end
            if (s8_in_valid && s8_in_ready) begin
                exp8_q.push_back(8'((sent + 1) * 2));
                sent++;
            end
            if (s8_out_valid && s8_out_ready) begin
                n_checks++;
                if (exp8_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got sum=%0d want no result", s8_sum); end
                else begin
                    logic [7:0] e;
                    e = exp8_q.pop_front();
                    if (s8_sum !== e) begin n_fail++; $display("FAIL bp_order: got %0d want %0d", s8_sum, e); end
                end
                got++;
            end
            tick();
        end
        n_checks++; if (got !== 5) begin n_fail++; $display("FAIL bp_count: got %0d results want 5", got); end
        s8_in_valid = 1'b0;
        s8_out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight;
        s8_out_ready = 1'b1;
        s8_in_valid = 1'b1; s8_a = 8'd3; s8_b = 8'd4; s8_cin = 1'b0;
        tick();
        s8_a = 8'd5; s8_b = 8'd6;
        tick();
        s8_in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_checks++; if (s8_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", s8_out_valid); end
        n_checks++; if (s8_sum !== 8'd0 || s8_cout !== 1'b0) begin n_fail++; $display("FAIL midrst_sum: got %0d c=%b want 0 0", s8_sum, s8_cout); end
        n_checks++; if (s8_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", s8_in_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (s8_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: out_valid got %b want 0 (cycle %0d)", s8_out_valid, i); end
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int n_out = 0;
        int first = -1;
        int last = -1;
        exp32_q.delete();
        s32_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            s32_in_valid = (sent < 8);
            s32_a = $urandom; s32_b = $urandom; s32_cin = 1'($urandom_range(0, 1));
            #1;
            if (s32_out_valid) begin
                n_checks++;
                if (exp32_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got sum=%h want no result", s32_sum); end
                else begin
                    logic [32:0] e;
                    e = exp32_q.pop_front();
                    if ({s32_cout, s32_sum} !== e) begin n_fail++; $display("FAIL b2b_result: got %h want %h", {s32_cout, s32_sum}, e); end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n_out++;
            end
            if (s32_in_valid && s32_in_ready) begin
                exp32_q.push_back(ref_add(32, s32_a, s32_b, s32_cin));
                sent++;
            end
            tick();
        end
        s32_in_valid = 1'b0;
        n_checks++; if (first !== 4) begin n_fail++; $display("FAIL b2b_latency: first result at cycle %0d want 4", first); end
        n_checks++; if (n_out !== 8 || last - first !== 7) begin n_fail++; $display("FAIL b2b_throughput: got %0d results over %0d cycles want 8 over 8", n_out, last - first + 1); end
    endtask

    task automatic test_random;
        bit prev_stall = 0;
        logic [32:0] held = '0;
        int accepted = 0;
        int delivered = 0;
        exp32_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            s32_in_valid  = ($urandom_range(0, 3) != 0);
            s32_a = $urandom; s32_b = $urandom; s32_cin = 1'($urandom_range(0, 1));
            if (cyc % 50 < 5) begin s32_a = 32'hFFFF_FFFF; s32_b = 32'($urandom_range(0, 2)); end
            s32_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_checks++;
            if (s32_in_ready !== !(s32_out_valid && !s32_out_ready)) begin
                n_fail++; $display("FAIL rnd_in_ready: got %b want %b", s32_in_ready, !(s32_out_valid && !s32_out_ready));
            end
            if (prev_stall) begin
                n_checks++;
                if (s32_out_valid !== 1'b1 || {s32_cout, s32_sum} !== held) begin
                    n_fail++; $display("FAIL rnd_stall_stable: got v=%b %h want v=1 %h", s32_out_valid, {s32_cout, s32_sum}, held);
                end
            end
            if (s32_out_valid && s32_out_ready) begin
                n_checks++;
                if (exp32_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra: got %h want no result", s32_sum); end
                else begin
                    logic [32:0] e;
                    e = exp32_q.pop_front();
                    if ({s32_cout, s32_sum} !== e) begin n_fail++; $display("FAIL rnd_result: got %h want %h", {s32_cout, s32_sum}, e); end
                end
                delivered++;
            end
            if (s32_in_valid && s32_in_ready) begin
                exp32_q.push_back(ref_add(32, s32_a, s32_b, s32_cin));
                accepted++;
            end
            prev_stall = s32_out_valid && !s32_out_ready;
            held = {s32_cout, s32_sum};
            tick();
        end
        s32_in_valid = 1'b0;
        s32_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp32_q.size() > 0; cyc++) begin
            if (s32_out_valid) begin
                logic [32:0] e;
                e = exp32_q.pop_front();
                n_checks++;
                if ({s32_cout, s32_sum} !== e) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", {s32_cout, s32_sum}, e); end
                delivered++;
            end
            tick();
        end
        n_checks++; if (delivered !== accepted) begin n_fail++; $display("FAIL rnd_count: delivered %0d want %0d", delivered, accepted); end
        n_checks++; if (s32_out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_dup: out_valid got %b want 0 after drain", s32_out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        s8_in_valid = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_out_ready = 1'b1;
        s32_in_valid = 1'b0; s32_a = '0; s32_b = '0; s32_cin = 1'b0; s32_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
